// File: rtl/problema1_pio_pkg.sv
// Shared constants and types for the start-of-frame output PIO.
package problema1_pio_pkg;

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_PULSE    = 3'd1;
  localparam logic [2:0] ADDR_STATUS   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  localparam int ST_BUSY = 0;
  localparam int ST_OVR  = 1;
  localparam int ST_DONE = 2;

  typedef enum logic {
    PS_IDLE   = 1'b0,
    PS_ACTIVE = 1'b1
  } pstate_t;

endpackage

// File: rtl/problema1_pulse_gen.sv
// Timed strobe generator: a length-N load yields strobe high for exactly N
// cycles. Loads while active are refused and reported; zero-length loads
// are ignored in both states.
module problema1_pulse_gen
  import problema1_pio_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] len,
  output logic             strobe,
  output logic             done_evt,
  output logic             reject_evt
);

  pstate_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             load_ok;

  assign load_ok = load && (len != '0);
  assign strobe  = (state == PS_ACTIVE);

  // State and counter registers; reset drops the strobe with no clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= PS_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and one-cycle event flags.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    done_evt   = 1'b0;
    reject_evt = 1'b0;
    case (state)
      PS_IDLE: begin
        if (load_ok) begin
          state_nxt = PS_ACTIVE;
          cnt_nxt   = len;
        end
      end
      PS_ACTIVE: begin
        cnt_nxt    = cnt - CNT_W'(1);
        reject_evt = load_ok;
        // Last strobe cycle: leave on this edge and flag completion.
        if (cnt == CNT_W'(1)) begin
          state_nxt = PS_IDLE;
          done_evt  = 1'b1;
        end
      end
      default: state_nxt = PS_IDLE;
    endcase
  end

endmodule

// File: rtl/problema1_startframe.sv
// Avalon-MM output PIO: level output register, timed start-of-frame
// strobe, sticky W1C status and registered readback.
// Optional OUTSET/OUTCLEAR registers: define PROBLEMA1_STARTFRAME_OUTSETCLR_EN.
module problema1_startframe
  import problema1_pio_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             strobe_out
);

  logic             wr;
  logic [WIDTH-1:0] data_reg;
  logic             ovr, done;
  logic             done_evt, reject_evt;
  logic [31:0]      rd_mux;
  logic [WIDTH-1:0] wdata;
  logic             w1c;

  assign wr       = chipselect & ~write_n;
  assign wdata    = writedata[WIDTH-1:0];
  assign w1c      = wr && (address == ADDR_STATUS);
  assign out_port = data_reg;

  problema1_pulse_gen #(.CNT_W(CNT_W)) u_pulse (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (wr && (address == ADDR_PULSE)),
    .len        (writedata[CNT_W-1:0]),
    .strobe     (strobe_out),
    .done_evt   (done_evt),
    .reject_evt (reject_evt)
  );

  // Output data register with direct write and optional bit set/clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_reg <= RESET_VALUE;
    end else if (wr) begin
      case (address)
        ADDR_DATA:     data_reg <= wdata;
`ifdef PROBLEMA1_STARTFRAME_OUTSETCLR_EN
        ADDR_OUTSET:   data_reg <= data_reg | wdata;
        ADDR_OUTCLEAR: data_reg <= data_reg & ~wdata;
`endif
        default:       data_reg <= data_reg;
      endcase
    end
  end

  // Sticky status bits; a new event on the same edge as its W1C wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr  <= 1'b0;
      done <= 1'b0;
    end else begin
      ovr  <= reject_evt | (ovr  & ~(w1c & writedata[ST_OVR]));
      done <= done_evt   | (done & ~(w1c & writedata[ST_DONE]));
    end
  end

  // Read mux; write-only, set/clear and reserved addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA: rd_mux = 32'(data_reg);
      ADDR_STATUS: begin
        rd_mux[ST_BUSY] = strobe_out;
        rd_mux[ST_OVR]  = ovr;
        rd_mux[ST_DONE] = done;
      end
      default: rd_mux = '0;
    endcase
  end

  // Registered readback every cycle, independent of chipselect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

endmodule

// File: tb/tb_problema1_startframe.sv
// Directed bench for problema1_startframe (WIDTH=8, CNT_W=16).
module tb_problema1_startframe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [2:0]       address = '0;
  logic             chipselect = 1'b0;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] out_port;
  logic             strobe_out;

  int checks = 0;
  int failures = 0;

  problema1_startframe #(.WIDTH(WIDTH), .CNT_W(CNT_W), .RESET_VALUE(8'h00)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .strobe_out (strobe_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [7:0]  exp_out;
    logic [31:0] exp_rd;
  } vec_t;

`ifdef PROBLEMA1_STARTFRAME_OUTSETCLR_EN
  localparam logic [7:0] EXP_SET = 8'hAF;
  localparam logic [7:0] EXP_CLR = 8'hAC;
`else
  localparam logic [7:0] EXP_SET = 8'h0F;
  localparam logic [7:0] EXP_CLR = 8'h0F;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a;
    tick();
  endtask

  // Count remaining strobe-high samples, bounded.
  task automatic count_high(output int n);
    n = 0;
    while (strobe_out && n < 200) begin
      n++;
      tick();
    end
  endtask

  vec_t vecs[$];
  int   n;

  initial begin
    vecs = '{
      '{1'b1, 3'd0, 32'h0000_0001, 8'h01, 32'h0},
      '{1'b0, 3'd0, 32'h0,         8'h01, 32'h0000_0001},
      '{1'b1, 3'd0, 32'h0000_005A, 8'h5A, 32'h0},
      '{1'b0, 3'd0, 32'h0,         8'h5A, 32'h0000_005A},
      '{1'b1, 3'd0, 32'hFFFF_F1FF, 8'hFF, 32'h0},
      '{1'b0, 3'd0, 32'h0,         8'hFF, 32'h0000_00FF},
      '{1'b0, 3'd1, 32'h0,         8'hFF, 32'h0},
      '{1'b1, 3'd3, 32'h0000_0012, 8'hFF, 32'h0},
      '{1'b0, 3'd3, 32'h0,         8'hFF, 32'h0},
      '{1'b0, 3'd6, 32'h0,         8'hFF, 32'h0},
      '{1'b0, 3'd7, 32'h0,         8'hFF, 32'h0},
      '{1'b0, 3'd2, 32'h0,         8'hFF, 32'h0},
      '{1'b1, 3'd0, 32'h0000_000F, 8'h0F, 32'h0},
      '{1'b1, 3'd4, 32'h0000_00A0, EXP_SET, 32'h0},
      '{1'b1, 3'd5, 32'h0000_0003, EXP_CLR, 32'h0},
      '{1'b0, 3'd4, 32'h0,         EXP_CLR, 32'h0},
      '{1'b0, 3'd5, 32'h0,         EXP_CLR, 32'h0}
    };

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_port", 32'(out_port), 32'h0);
    chk("reset_strobe", 32'(strobe_out), 32'h0);
    chk("reset_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick();

    // Register vectors
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data);
      else begin
        rd(vecs[i].addr);
        chk($sformatf("vec%0d_readdata", i), readdata, vecs[i].exp_rd);
      end
      chk($sformatf("vec%0d_out_port", i), 32'(out_port), 32'(vecs[i].exp_out));
    end

    // Write without chipselect is ignored
    address = 3'd0; writedata = 32'h77; write_n = 1'b0; chipselect = 1'b0;
    tick();
    write_n = 1'b1;
    chk("nocs_out_port", 32'(out_port), 32'(EXP_CLR));

    // PULSE=5
    wr(3'd1, 32'd5);
    count_high(n);
    chk("pulse5_width", n, 5);
    rd(3'd2);
    chk("pulse5_status", readdata, 32'h4);
    wr(3'd2, 32'h4);
    rd(3'd2);
    chk("w1c_done_status", readdata, 32'h0);

    // PULSE=10 then PULSE=3 while active
    wr(3'd1, 32'd10);
    chk("p10_start", 32'(strobe_out), 32'h1);
    wr(3'd1, 32'd3);
    count_high(n);
    chk("p10_width", n + 1, 10);
    rd(3'd2);
    chk("ovr_done_status", readdata, 32'h6);

    // PULSE=0 while idle: no pulse, status unchanged
    wr(3'd1, 32'd0);
    chk("p0_strobe", 32'(strobe_out), 32'h0);
    tick();
    chk("p0_strobe_later", 32'(strobe_out), 32'h0);
    rd(3'd2);
    chk("p0_status", readdata, 32'h6);
    wr(3'd2, 32'h2);
    rd(3'd2);
    chk("w1c_ovr_only", readdata, 32'h4);
    wr(3'd2, 32'h6);

    // BUSY readback during a pulse, and DATA write during ACTIVE
    wr(3'd1, 32'd4);
    rd(3'd2);
    chk("busy_status", readdata, 32'h1);
    wr(3'd0, 32'h33);
    chk("data_during_pulse", 32'(out_port), 32'h33);
    chk("strobe_after_data", 32'(strobe_out), 32'h1);
    count_high(n);
    chk("p4_width", n + 2, 4);
    rd(3'd2);
    chk("p4_status", readdata, 32'h4);

    // N=1 with DONE W1C landing on the DONE edge: set wins
    wr(3'd1, 32'd1);
    chk("p1_strobe_on", 32'(strobe_out), 32'h1);
    wr(3'd2, 32'h4);
    chk("p1_strobe_off", 32'(strobe_out), 32'h0);
    rd(3'd2);
    chk("set_wins_status", readdata, 32'h4);
    wr(3'd2, 32'h4);

    // Asynchronous reset mid-pulse
    wr(3'd1, 32'd20);
    tick();
    rd(3'd0);
    chk("pre_reset_strobe", 32'(strobe_out), 32'h1);
    reset_n = 1'b0;
    #2;
    chk("async_strobe", 32'(strobe_out), 32'h0);
    chk("async_out_port", 32'(out_port), 32'h0);
    chk("async_readdata", readdata, 32'h0);
    tick();
    reset_n = 1'b1;
    rd(3'd2);
    chk("post_reset_status", readdata, 32'h0);
    tick();
    chk("post_reset_strobe", 32'(strobe_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/problema1_startframe.md
Name: problema1_startframe

Overview:
- Avalon-MM slave output PIO. It is the write-side counterpart of the frame-status input ports. The CPU uses it to drive a level output (out_port) and to launch a timed start-of-frame strobe (strobe_out) into the frame-processing hardware.
- It also provides register readback, a busy/overrun/done status register and optional bit-set/bit-clear registers.

Parameters:
- WIDTH, 1, out_port width (1..32).
- CNT_W, 16, pulse-length counter width (1..32).
- RESET_VALUE, 0, out_port value after reset (WIDTH bits).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- address  input  3  register word address.
- chipselect  input  1  slave select.
- write_n  input  1  active-low write strobe.
- writedata  input  32  write data.
- readdata  output  32  registered read data.
- out_port  output  WIDTH  level output, equal to data_reg.
- strobe_out  output  1  start-of-frame pulse.

Behaviour:
- Interface: one clock (clk); reset_n asynchronous active-low. All state clears immediately when reset_n = 0, with no clock required.
- Reset values:
  - data_reg = RESET_VALUE, so out_port = RESET_VALUE.
  - strobe_out = 0, counter = 0.
  - sticky status bits = 0, readdata = 0.
- Write qualifier: wr = chipselect & ~write_n. Register effects appear on the edge that samples wr, so outputs change 1 cycle after the write.
- Register map (word addresses):
  - 0 DATA, R/W. Write: data_reg <= writedata[WIDTH-1:0]. Read: zero-extended data_reg.
  - 1 PULSE, W. Write N = writedata[CNT_W-1:0]:
    - N = 0: ignored.
    - IDLE and N > 0: load counter with N and go ACTIVE.
    - ACTIVE: write ignored and OVR sticky bit set.
    - Read returns 0.
  - 2 STATUS, R/W1C.
    - bit0 BUSY (read-only, = strobe_out).
    - bit1 OVR.
    - bit2 DONE.
    - Writing 1 to bit1 or bit2 clears that bit; writing 0 leaves it unchanged.
  - 3: reserved. Reads 0, writes ignored.
  - 4 OUTSET: data_reg <= data_reg | writedata[WIDTH-1:0] (optional feature only).
  - 5 OUTCLEAR: data_reg <= data_reg & ~writedata[WIDTH-1:0] (optional feature only).
  - 6, 7: reserved. Reads 0, writes ignored.
- Pulse state machine:
  - IDLE: strobe_out = 0. Accepted PULSE write moves to ACTIVE.
  - ACTIVE: strobe_out = 1; counter decrements each cycle. When counter = 1, the next state is IDLE and DONE is set on that same edge.
  - strobe_out is therefore high for exactly N consecutive cycles, starting the cycle after the write.
  - Maximum pulse length is 2^CNT_W - 1 cycles.
- Simultaneous events:
  - The DONE-setting edge coincides with a W1C of DONE: set wins.
  - An OVR-setting write is on a different address from a STATUS write, so it cannot coincide with one.
- Read path:
  - readdata is registered every clock from the address mux, regardless of chipselect. Read latency is 1.
  - Read of STATUS returns the pre-edge value (BUSY reflects strobe_out before the edge).
- DATA writes and the pulse machine are independent; a DATA write during ACTIVE does not disturb the pulse.
- Reset mid-pulse: strobe_out drops asynchronously and no DONE is recorded.

Optional Feature:
- Macro: PROBLEMA1_STARTFRAME_OUTSETCLR_EN.
- Defined: addresses 4 (OUTSET) and 5 (OUTCLEAR) are active as specified; both read 0.
- Undefined: addresses 4 and 5 behave as reserved (writes ignored, reads 0), and no set/clear logic is synthesised.

Decomposition:
- Package problema1_pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_PULSE=1, ADDR_STATUS=2, ADDR_OUTSET=4, ADDR_OUTCLEAR=5;
  - status bit indices ST_BUSY=0, ST_OVR=1, ST_DONE=2;
  - pulse state enum {PS_IDLE, PS_ACTIVE}.
- Sub-module problema1_pulse_gen:
  - contains the counter and the IDLE/ACTIVE machine;
  - inputs: load, len[CNT_W-1:0];
  - outputs: strobe, done_evt, reject_evt.
- Top level holds the register file, W1C logic and read mux.

Test Plan:
- Reset with RESET_VALUE=0, WIDTH=1 -> out_port=0, strobe_out=0, readdata=0; assert reset_n mid-operation -> all outputs return to 0 asynchronously.
- Write DATA=0x1, then read addr 0 -> out_port=1 one cycle after the write; readdata=0x00000001 one cycle after the read address is presented.
- Write PULSE=5 -> strobe_out high exactly 5 cycles, starting the cycle after the write; STATUS read afterwards = 0x4 (DONE); write STATUS=0x4, then read -> 0x0.
- Write PULSE=10, then PULSE=3 during ACTIVE -> strobe_out stays high exactly 10 cycles total; STATUS after the pulse = 0x6 (OVR|DONE). Write PULSE=0 while IDLE -> no pulse, STATUS unchanged.
- With macro defined and WIDTH=8: DATA=0x0F, OUTSET=0xA0, OUTCLEAR=0x03 -> out_port = 0xAF, then 0xAC. Without macro, the same writes -> out_port stays 0x0F.
- Pulse with N=1 while a STATUS W1C of DONE lands on the DONE edge -> strobe_out high 1 cycle; DONE reads 1 (set wins).
